programmable_interconnect_array_cfg: RTL

//  Configurable PIA model for the MAX7000 simulation. Each PIA output line routes one global

---
 rtl/programmable_interconnect_array_cfg_if.sv | 34 +++
 rtl/programmable_interconnect_array_cfg.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/programmable_interconnect_array_cfg_if.sv
// Configuration handshake bundle for the configurable PIA.
// The loader drives the master side; the PIA block is the slave.
interface programmable_interconnect_array_cfg_if;
    logic cfg_start;
    logic cfg_erase;
    logic cfg_valid;
    logic cfg_data;
    logic cfg_ready;
    logic cfg_busy;
    logic cfg_error;
    logic configured;

    modport master (
        output cfg_start,
        output cfg_erase,
        output cfg_valid,
        output cfg_data,
        input  cfg_ready,
        input  cfg_busy,
        input  cfg_error,
        input  configured
    );

    modport slave (
        input  cfg_start,
        input  cfg_erase,
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready,
        output cfg_busy,
        output cfg_error,
        output configured
    );
endinterface

// File: rtl/programmable_interconnect_array_cfg.sv
// Configurable programmable interconnect array for the MAX7000 model.
// Every LAB input line picks one global source (dedicated input, I/O pin or
// macrocell feedback) through a select field. Select fields arrive as a
// serial bitstream into a shadow register and are committed all at once,
// only if every field names an existing source.
module programmable_interconnect_array_cfg #(
    parameter int lab_count                 = 2,
    parameter int lab_input_count           = 36,
    parameter int io_pin_count              = 32,
    parameter int macrocell_count           = 32,
    parameter int dedicated_input_pin_count = 4
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [dedicated_input_pin_count-1:0]   dedicated_input_pin_signals,
    input  logic [io_pin_count-1:0]                io_pin_signals,
    input  logic [macrocell_count-1:0]             macrocell_output_signals,
    programmable_interconnect_array_cfg_if.slave   cfgBus,
    output logic [lab_count*lab_input_count-1:0]   pia_signals
);

    localparam int SrcCount   = dedicated_input_pin_count + io_pin_count + macrocell_count;
    localparam int LineCount  = lab_count * lab_input_count;
    localparam int SelWidth   = $clog2(SrcCount + 1);
    localparam int CfgBits    = LineCount * SelWidth;
    localparam int CountWidth = $clog2(CfgBits + 1);
    localparam int SrcSpan    = 1 << SelWidth;

    localparam logic [SelWidth-1:0]   SelMax   = SelWidth'(SrcCount);
    localparam logic [CountWidth-1:0] LastBeat = CountWidth'(CfgBits - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCheck
    } state_t;

    state_t                 state_q;
    logic [CfgBits-1:0]     shadow_q;
    logic [CfgBits-1:0]     commit_q;
    logic [CountWidth-1:0]  bitCount_q;
    logic                   configured_q;
    logic                   cfgError_q;
    logic [LineCount-1:0]   pia_q;
    logic [LineCount-1:0]   pia_d;
    logic [SrcSpan-1:0]     srcExt;
    logic                   rangeBad;

    // Field 0 is shifted in first, so it ends up in the top bits of the vector.
    function automatic logic [SelWidth-1:0] fieldOf(input logic [CfgBits-1:0] bits, input int j);
        return bits[CfgBits-1-j*SelWidth -: SelWidth];
    endfunction

    // Source bus padded to the full select range so selects 0 and >S read a zero.
    always_comb begin
        srcExt = '0;
        srcExt[SrcCount-1:0] = {macrocell_output_signals, io_pin_signals, dedicated_input_pin_signals};
    end

    // Flag a shadow image that names a source beyond the last one.
    always_comb begin
        rangeBad = 1'b0;
        for (int j = 0; j < LineCount; j++) begin
            if (fieldOf(shadow_q, j) > SelMax) begin
                rangeBad = 1'b1;
            end
        end
    end

    // Route each line from the committed selects; unconfigured or empty selects give 0.
    always_comb begin
        pia_d = '0;
        for (int j = 0; j < LineCount; j++) begin
            if (configured_q && (fieldOf(commit_q, j) != '0) && (fieldOf(commit_q, j) <= SelMax)) begin
                pia_d[j] = srcExt[fieldOf(commit_q, j) - 1'b1];
            end
        end
    end

    // Load sequencer: erase overrides everything, a load commits only after a clean range check.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            shadow_q     <= '0;
            commit_q     <= '0;
            bitCount_q   <= '0;
            configured_q <= 1'b0;
            cfgError_q   <= 1'b0;
        end else if (cfgBus.cfg_erase) begin
            state_q      <= StIdle;
            shadow_q     <= '0;
            commit_q     <= '0;
            bitCount_q   <= '0;
            configured_q <= 1'b0;
            cfgError_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cfgBus.cfg_start) begin
                        state_q    <= StLoad;
                        bitCount_q <= '0;
                        cfgError_q <= 1'b0;
                    end
                end
                StLoad: begin
                    if (cfgBus.cfg_valid) begin
                        shadow_q   <= {shadow_q[CfgBits-2:0], cfgBus.cfg_data};
                        bitCount_q <= bitCount_q + 1'b1;
                        if (bitCount_q == LastBeat) begin
                            state_q <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (rangeBad) begin
                        cfgError_q <= 1'b1;
                    end else begin
                        commit_q     <= shadow_q;
                        configured_q <= 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Registered LAB input lines, one cycle behind the sources and the committed routing.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pia_q <= '0;
        end else begin
            pia_q <= pia_d;
        end
    end

    assign pia_signals       = pia_q;
    assign cfgBus.cfg_ready  = (state_q == StLoad);
    assign cfgBus.cfg_busy   = (state_q != StIdle);
    assign cfgBus.cfg_error  = cfgError_q;
    assign cfgBus.configured = configured_q;

endmodule
